// File: rtl/pc_branch_ctrl.sv
// Program-counter sequencer: hold / step / PC-relative branch through an external
// branch-target LUT, bracketed by an IDLE -> RUN -> DONE execution state machine.
module pc_branch_ctrl #(
    parameter int D     = 12,
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic             halt,
    input  logic             stall,
    input  logic             branch_en,
    input  logic             taken,
    input  logic [2:0]       lut_idx,
    input  logic [D-1:0]     target,
    output logic [2:0]       how_high,
    output logic [D-1:0]     prog_ctr,
    output logic             running,
    output logic             done,
    output logic [CNT_W-1:0] branch_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [D-1:0]     PC_ONE  = {{(D-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [D-1:0]     pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             running_q, running_d;
    logic             done_q, done_d;
    logic             branch_taken;

    // LUT lookup is purely combinational; target returns in the same cycle.
    assign how_high     = lut_idx;
    assign branch_taken = branch_en && taken;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        running_d = running_q;
        done_d    = done_q;

        case (state_q)
            IDLE: begin
                pc_d = '0;
                if (start) begin
                    state_d   = RUN;
                    cnt_d     = '0;
                    running_d = 1'b1;
                    done_d    = 1'b0;
                end
            end

            RUN: begin
                if (halt) begin
                    state_d   = DONE;
                    running_d = 1'b0;
                    done_d    = 1'b1;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (branch_taken) begin
                    // Unsigned D-bit add is the two's-complement signed add modulo 2^D.
                    pc_d = pc_q + target;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    pc_d = pc_q + PC_ONE;
                end
            end

            DONE: begin
                if (start) begin
                    state_d   = RUN;
                    pc_d      = '0;
                    cnt_d     = '0;
                    running_d = 1'b1;
                    done_d    = 1'b0;
                end
            end

            default: begin
                state_d   = IDLE;
                pc_d      = '0;
                cnt_d     = '0;
                running_d = 1'b0;
                done_d    = 1'b0;
            end
        endcase
    end

    assign prog_ctr     = pc_q;
    assign branch_count = cnt_q;
    assign running      = running_q;
    assign done         = done_q;

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Self-checking bench for pc_branch_ctrl: directed scenarios plus randomized traffic
// compared against an arithmetic reference model of the sequencer.
module tb_pc_branch_ctrl;

    localparam int D     = 12;
    localparam int CNT_W = 8;
    localparam int PC_MOD  = 1 << D;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             start, halt, stall, branch_en, taken;
    logic [2:0]       lut_idx;
    logic [D-1:0]     target;
    logic [2:0]       how_high;
    logic [D-1:0]     prog_ctr;
    logic             running, done;
    logic [CNT_W-1:0] branch_count;

    int checks = 0;
    int errors = 0;

    // Behavioural LUT: signed offsets indexed by how_high
    int lut [8];
    logic [31:0] lut_word;

    // Reference model: 0 = idle, 1 = run, 2 = done
    int m_state, m_pc, m_cnt;

    always #5 Clk = ~Clk;

    always_comb begin
        lut_word = lut[how_high];
        target   = lut_word[D-1:0];
    end

    pc_branch_ctrl #(.D(D), .CNT_W(CNT_W)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .start        (start),
        .halt         (halt),
        .stall        (stall),
        .branch_en    (branch_en),
        .taken        (taken),
        .lut_idx      (lut_idx),
        .target       (target),
        .how_high     (how_high),
        .prog_ctr     (prog_ctr),
        .running      (running),
        .done         (done),
        .branch_count (branch_count)
    );

    function automatic int wrap_pc(input int v);
        return ((v % PC_MOD) + PC_MOD) % PC_MOD;
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_pc    = 0;
        m_cnt   = 0;
    endtask

    task automatic model_edge();
        case (m_state)
            0: if (start) begin m_state = 1; m_pc = 0; m_cnt = 0; end
            1: begin
                if (halt) m_state = 2;
                else if (stall) ;
                else if (branch_en && taken) begin
                    m_pc = wrap_pc(m_pc + lut[lut_idx]);
                    if (m_cnt < CNT_MAX) m_cnt++;
                end else m_pc = wrap_pc(m_pc + 1);
            end
            default: if (start) begin m_state = 1; m_pc = 0; m_cnt = 0; end
        endcase
    endtask

    task automatic clear_inputs();
        start = 0; halt = 0; stall = 0; branch_en = 0; taken = 0; lut_idx = 3'd0;
    endtask

    task automatic tick();
        @(posedge Clk);
        model_edge();
        #1;
    endtask

    task automatic step_n(input int n);
        clear_inputs();
        repeat (n) tick();
    endtask

    // Halt (if running) then start, leaving the DUT in RUN at PC 0.
    task automatic restart();
        clear_inputs();
        halt = 1; tick();
        halt = 0; start = 1; tick();
        start = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        Reset = 1; lut_idx = 3'd5;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        checks++; if (prog_ctr !== 12'd0) begin errors++; $display("FAIL reset_pc got %0d want 0", prog_ctr); end
        checks++; if (branch_count !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", branch_count); end
        checks++; if (running !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_flags got run=%b done=%b want 0 0", running, done); end
        checks++; if (how_high !== 3'd5) begin errors++; $display("FAIL reset_how_high got %0d want 5", how_high); end
        // start presented together with reset release is taken at the following edge
        @(negedge Clk);
        Reset = 0; start = 1;
        tick();
        start = 0;
        checks++; if (running !== 1'b1 || prog_ctr !== 12'd0) begin errors++; $display("FAIL reset_start got run=%b pc=%0d want 1 0", running, prog_ctr); end
    endtask

    task automatic test_step();
        clear_inputs();
        for (int i = 1; i <= 5; i++) begin
            lut_idx = 3'($urandom_range(0, 7));
            #1;
            checks++; if (how_high !== lut_idx) begin errors++; $display("FAIL step_how_high got %0d want %0d", how_high, lut_idx); end
            tick();
            checks++; if (prog_ctr !== 12'(i) || running !== 1'b1 || done !== 1'b0) begin
                errors++; $display("FAIL step_pc got pc=%0d run=%b done=%b want %0d 1 0", prog_ctr, running, done, i);
            end
        end
    endtask

    task automatic test_branch();
        restart();
        step_n(10);
        checks++; if (prog_ctr !== 12'd10) begin errors++; $display("FAIL branch_pre got %0d want 10", prog_ctr); end
        lut[1] = 15; lut_idx = 3'd1; branch_en = 1; taken = 1;
        tick();
        checks++; if (prog_ctr !== 12'd25 || branch_count !== 8'd1) begin errors++; $display("FAIL branch_fwd got pc=%0d cnt=%0d want 25 1", prog_ctr, branch_count); end
        step_n(35);
        lut[3] = -41; lut_idx = 3'd3; branch_en = 1; taken = 1;
        tick();
        checks++; if (prog_ctr !== 12'd19 || branch_count !== 8'd2) begin errors++; $display("FAIL branch_back got pc=%0d cnt=%0d want 19 2", prog_ctr, branch_count); end
    endtask

    task automatic test_not_taken_stall();
        restart();
        step_n(7);
        lut[1] = 15; lut_idx = 3'd1; branch_en = 1; taken = 0;
        tick();
        checks++; if (prog_ctr !== 12'd8 || branch_count !== 8'd0) begin errors++; $display("FAIL not_taken got pc=%0d cnt=%0d want 8 0", prog_ctr, branch_count); end
        stall = 1; taken = 1;
        tick();
        checks++; if (prog_ctr !== 12'd8 || branch_count !== 8'd0) begin errors++; $display("FAIL stall got pc=%0d cnt=%0d want 8 0", prog_ctr, branch_count); end
    endtask

    task automatic test_halt();
        restart();
        step_n(30);
        lut[2] = 9; lut_idx = 3'd2; halt = 1; branch_en = 1; taken = 1;
        tick();
        checks++; if (done !== 1'b1 || running !== 1'b0 || prog_ctr !== 12'd30 || branch_count !== 8'd0) begin
            errors++; $display("FAIL halt got done=%b run=%b pc=%0d cnt=%0d want 1 0 30 0", done, running, prog_ctr, branch_count);
        end
        halt = 0;
        tick();
        checks++; if (done !== 1'b1 || prog_ctr !== 12'd30) begin errors++; $display("FAIL done_hold got done=%b pc=%0d want 1 30", done, prog_ctr); end
        clear_inputs(); start = 1;
        tick();
        start = 0;
        checks++; if (prog_ctr !== 12'd0 || branch_count !== 8'd0 || running !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL restart got pc=%0d cnt=%0d run=%b done=%b want 0 0 1 0", prog_ctr, branch_count, running, done);
        end
    endtask

    task automatic test_wrap();
        restart();
        step_n(4095);
        checks++; if (prog_ctr !== 12'd4095) begin errors++; $display("FAIL wrap_pre got %0d want 4095", prog_ctr); end
        step_n(1);
        checks++; if (prog_ctr !== 12'd0) begin errors++; $display("FAIL wrap_step got %0d want 0", prog_ctr); end
        step_n(5);
        lut[2] = -375; lut_idx = 3'd2; branch_en = 1; taken = 1;
        tick();
        checks++; if (prog_ctr !== 12'd3726 || branch_count !== 8'd1) begin errors++; $display("FAIL wrap_branch got pc=%0d cnt=%0d want 3726 1", prog_ctr, branch_count); end
        lut[0] = 0; lut_idx = 3'd0;
        tick();
        checks++; if (prog_ctr !== 12'd3726 || branch_count !== 8'd2) begin errors++; $display("FAIL self_loop got pc=%0d cnt=%0d want 3726 2", prog_ctr, branch_count); end
        lut[4] = 1; lut_idx = 3'd4;
        repeat (300) tick();
        checks++; if (branch_count !== 8'd255) begin errors++; $display("FAIL saturate got %0d want 255", branch_count); end
        checks++; if (prog_ctr !== 12'd4026) begin errors++; $display("FAIL saturate_pc got %0d want 4026", prog_ctr); end
        clear_inputs();
    endtask

    task automatic test_async_reset();
        restart();
        step_n(100);
        checks++; if (prog_ctr !== 12'd100 || running !== 1'b1) begin errors++; $display("FAIL areset_pre got pc=%0d run=%b want 100 1", prog_ctr, running); end
        #3;
        Reset = 1;
        model_reset();
        #1;
        checks++; if (prog_ctr !== 12'd0 || running !== 1'b0 || done !== 1'b0 || branch_count !== 8'd0) begin
            errors++; $display("FAIL areset got pc=%0d run=%b done=%b cnt=%0d want 0 0 0 0", prog_ctr, running, done, branch_count);
        end
        #2;
        Reset = 0;
        step_n(5);
        checks++; if (prog_ctr !== 12'd0 || running !== 1'b0) begin errors++; $display("FAIL areset_idle got pc=%0d run=%b want 0 0", prog_ctr, running); end
    endtask

    task automatic test_random();
        int roll;
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) begin
                for (int k = 0; k < 8; k++) begin
                    lut[k] = (k == 7) ? int'($urandom_range(0, PC_MOD - 1)) - PC_MOD / 2
                                      : int'($urandom_range(0, 80)) - 40;
                end
            end
            roll      = int'($urandom_range(0, 99));
            start     = (roll < 3);
            halt      = ($urandom_range(0, 99) < 2);
            stall     = ($urandom_range(0, 99) < 15);
            branch_en = ($urandom_range(0, 99) < 40);
            taken     = $urandom_range(0, 1) == 1;
            lut_idx   = 3'($urandom_range(0, 7));
            #1;
            checks++; if (how_high !== lut_idx) begin errors++; $display("FAIL rnd_how_high cyc %0d got %0d want %0d", c, how_high, lut_idx); end
            tick();
            checks++; if (prog_ctr !== 12'(m_pc) || branch_count !== 8'(m_cnt) || running !== (m_state == 1) || done !== (m_state == 2)) begin
                errors++; $display("FAIL rnd_state cyc %0d got pc=%0d cnt=%0d run=%b done=%b want %0d %0d %0d %0d",
                                   c, prog_ctr, branch_count, running, done, m_pc, m_cnt, m_state == 1, m_state == 2);
            end
        end
        clear_inputs();
    endtask

    initial begin
        for (int k = 0; k < 8; k++) lut[k] = 0;
        clear_inputs();
        Reset = 1;
        model_reset();
        test_reset();
        test_step();
        test_branch();
        test_not_taken_stall();
        test_halt();
        test_wrap();
        test_async_reset();
        restart();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
